// File: rtl/mult_seq_ctrl.sv
// Sequences one signed 32x32 operand pair at a time through a multi-cycle Radix4 multiplier.
// Latency: res_valid rises START_CYCLES+MULT_LATENCY+1 edges after accept; HOLD stalls until res_ready.
module mult_seq_ctrl #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned MULT_LATENCY = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [15:0] done_count
);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t     state;
  logic [7:0] cnt;

  // Gated by rst so the first cycle after reset release already advertises readiness.
  assign op_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      mult_start <= 1'b0;
      mult_a     <= 32'd0;
      mult_b     <= 32'd0;
      res_valid  <= 1'b0;
      res_data   <= 64'd0;
      done_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            mult_a     <= op_a;
            mult_b     <= op_b;
            cnt        <= 8'd0;
            mult_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (cnt == 8'(START_CYCLES - 1)) begin
            cnt        <= 8'd0;
            mult_start <= 1'b0;
            state      <= WAIT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT: begin
          // Product settles MULT_LATENCY cycles after mult_start falls; sample on the edge after that.
          if (cnt == 8'(MULT_LATENCY)) begin
            res_data  <= mult_result;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomized self-checking bench for mult_seq_ctrl with a latency-accurate multiplier stand-in.
module tb_mult_seq_ctrl;
  localparam int S = 2;
  localparam int L = 18;
  localparam int EXP_LAT = S + L + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [63:0] mult_result = 64'd0;
  logic        op_ready, mult_start, res_valid;
  logic [31:0] mult_a, mult_b;
  logic [63:0] res_data;
  logic [15:0] done_count;

  int vectors = 0;
  int errors = 0;
  int exp_done = 0;

  mult_seq_ctrl #(.START_CYCLES(S), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .mult_start(mult_start), .mult_a(mult_a),
    .mult_b(mult_b), .mult_result(mult_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .done_count(done_count)
  );

  always #5 clk = ~clk;

  function automatic longint ref_mul(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  // Multiplier stand-in: presents the true product only once L full cycles have
  // elapsed since mult_start fell, and its complement before that.
  int     lcnt = 1000;
  longint prod;
  always @(negedge clk) begin
    prod = ref_mul(mult_a, mult_b);
    if (mult_start) lcnt = 0;
    else if (lcnt < 1000) lcnt++;
    mult_result = (lcnt > L) ? prod : ~prod;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one operation from a negedge through hand-off; returns to a negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                        output int wait_cyc, output int lat, output int starts,
                        output logic [63:0] data, output bit ab_ok, output bit hold_ok);
    logic [15:0] cnt_before;
    wait_cyc = 0;
    while (!op_ready && wait_cyc < 100) begin @(negedge clk); wait_cyc++; end
    op_valid = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    lat = 0;
    starts = int'(mult_start);
    ab_ok = (mult_a === a) && (mult_b === b);
    while (!res_valid && lat < 600) begin
      op_valid = 1'($urandom % 2); op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      lat++;
      starts += int'(mult_start);
      if (mult_a !== a || mult_b !== b) ab_ok = 0;
    end
    data = res_data;
    hold_ok = 1;
    cnt_before = done_count;
    for (int i = 0; i < stall; i++) begin
      op_valid = 1'($urandom % 2); res_ready = 1'b0;
      @(negedge clk);
      if (res_data !== data || !res_valid || op_ready || done_count !== cnt_before || mult_a !== a)
        hold_ok = 0;
    end
    op_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (mult_a !== a || mult_b !== b || res_data !== data) ab_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b1; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (op_ready !== 1'b0 || mult_start !== 1'b0 || res_valid !== 1'b0 || mult_a !== 32'd0 ||
        mult_b !== 32'd0 || res_data !== 64'd0 || done_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b start=%b rv=%b a=%h b=%h d=%h cnt=%h, required all zero",
               op_ready, mult_start, res_valid, mult_a, mult_b, res_data, done_count);
    end
    op_valid = 1'b0; res_ready = 1'b0; rst = 1'b0;
    #1;
    vectors++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b, required 1", op_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    run_op(32'd553524, 32'd840, 0, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors += 4;
    if (st != S) begin errors++; $display("FAIL basic_start_cycles: got %0d, required %0d", st, S); end
    if (lat != EXP_LAT) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, EXP_LAT); end
    if (d !== 64'd464960160) begin errors++; $display("FAIL basic_data: got %0d, required 464960160", $signed(d)); end
    if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL basic_done: got %0d, required %0d", done_count, exp_done); end
  endtask

  task automatic test_back_to_back();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    run_op(-32'sd259, 32'd553524, 0, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors++;
    if (d !== -64'sd143362716) begin errors++; $display("FAIL b2b_data1: got %0d, required -143362716", $signed(d)); end
    run_op(-32'sd2, -32'sd2, 0, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors += 4;
    if (w != 0) begin errors++; $display("FAIL b2b_accept_gap: got %0d idle cycles, required 0", w); end
    if (d !== 64'd4) begin errors++; $display("FAIL b2b_data2: got %0d, required 4", $signed(d)); end
    if (lat != EXP_LAT) begin errors++; $display("FAIL b2b_latency: got %0d, required %0d", lat, EXP_LAT); end
    if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL b2b_done: got %0d, required %0d", done_count, exp_done); end
  endtask

  task automatic test_hold_backpressure();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    run_op(32'd5, 32'd0, 5, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors += 4;
    if (d !== 64'd0) begin errors++; $display("FAIL hold_data: got %h, required 0", d); end
    if (!hk) begin errors++; $display("FAIL hold_stable: got unstable hold phase, required stable"); end
    if (!abk) begin errors++; $display("FAIL hold_operands: got operands changed, required stable"); end
    if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL hold_done: got %0d, required %0d", done_count, exp_done); end
    vectors++;
    if (res_data !== 64'd0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL hold_retain: got data=%h rv=%b, required 0/0", res_data, res_valid);
    end
  endtask

  task automatic test_big_operands();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    logic [31:0] a, b;
    a = -32'sd1199060305; b = -32'sd2005095693;
    run_op(a, b, 2, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors += 3;
    if (d !== 64'(ref_mul(a, b))) begin errors++; $display("FAIL big_data: got %0d, required %0d", $signed(d), ref_mul(a, b)); end
    if (!abk) begin errors++; $display("FAIL big_operands: got mult_a=%h mult_b=%h, required %h %h", mult_a, mult_b, a, b); end
    if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL big_done: got %0d, required %0d", done_count, exp_done); end
  endtask

  task automatic test_random();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    logic [31:0] a, b;
    for (int n = 0; n < 10; n++) begin
      a = $urandom; b = $urandom;
      if (n == 0) a = 32'h8000_0000;
      if (n == 1) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      run_op(a, b, int'($urandom_range(0, 3)), w, lat, st, d, abk, hk);
      exp_done = (exp_done + 1) % 65536;
      vectors++;
      if (d !== 64'(ref_mul(a, b)) || lat != EXP_LAT || st != S || !abk || !hk ||
          done_count !== 16'(exp_done)) begin
        errors++;
        $display("FAIL random_op%0d: got d=%h lat=%0d st=%0d ab=%0b hold=%0b cnt=%0d, required d=%h lat=%0d st=%0d 1 1 cnt=%0d",
                 n, d, lat, st, abk, hk, done_count, 64'(ref_mul(a, b)), EXP_LAT, S, exp_done);
      end
    end
  endtask

  task automatic test_reset_abort();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    op_valid = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (S + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mult_start !== 1'b0 || res_valid !== 1'b0 || done_count !== 16'd0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got start=%b rv=%b cnt=%0d rdy=%b, required 0 0 0 0",
               mult_start, res_valid, done_count, op_ready);
    end
    rst = 1'b0;
    exp_done = 0;
    #1;
    vectors++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", op_ready); end
    run_op(32'd1, 32'd1348760118, 0, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors += 3;
    if (d !== 64'd1348760118) begin errors++; $display("FAIL abort_next_data: got %0d, required 1348760118", $signed(d)); end
    if (lat != EXP_LAT) begin errors++; $display("FAIL abort_next_latency: got %0d, required %0d", lat, EXP_LAT); end
    if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL abort_next_done: got %0d, required %0d", done_count, exp_done); end
  endtask

  task automatic test_done_wrap();
    int w, lat, st; logic [63:0] d; bit abk, hk;
    force dut.done_count = 16'hFFFF;
    #1;
    release dut.done_count;
    exp_done = 65535;
    @(negedge clk);
    run_op($urandom, $urandom, 1, w, lat, st, d, abk, hk);
    exp_done = (exp_done + 1) % 65536;
    vectors++;
    if (done_count !== 16'(exp_done)) begin errors++; $display("FAIL done_wrap: got %h, required %h", done_count, 16'(exp_done)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_backpressure();
    test_big_operands();
    test_random();
    test_reset_abort();
    test_done_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
